// File: rtl/dnn_result_pkg.sv
// Shared types and helpers for the DNN result sink: FSM states, result record and argmax.
package dnn_result_pkg;

   localparam int unsigned PkgBitSize = 4;
   localparam int unsigned PkgNumOut  = 2;

   function automatic int unsigned class_width(input int unsigned num_out);
      return (num_out > 1) ? $clog2(num_out) : 1;
   endfunction

   function automatic int unsigned result_width(input int unsigned bit_size,
                                                input int unsigned num_out);
      return class_width(num_out) + bit_size;
   endfunction

   localparam int unsigned PkgClassW = class_width(PkgNumOut);

   typedef enum logic [1:0] {StCollect, StDrain, StFinished} sink_state_t;

   typedef logic [PkgNumOut-1:0][PkgBitSize-1:0] score_vec_t;

   typedef struct packed {
      logic [PkgClassW-1:0]  cls;
      logic [PkgBitSize-1:0] score;
   } result_t;

   // Strict '>' so the lowest lane index wins a tie.
   function automatic result_t argmax(input score_vec_t vec);
      result_t best;
      best.cls   = '0;
      best.score = vec[0];
      for (int unsigned i = 1; i < PkgNumOut; i++) begin
         if ($signed(vec[i]) > $signed(best.score)) begin
            best.cls   = PkgClassW'(i);
            best.score = vec[i];
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
module result_fifo
   import dnn_result_pkg::*;
#(
   parameter int unsigned Width = 5,
   parameter int unsigned Depth = 4
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && (!full || do_pop) && !clear;
   assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/dnn_result_sink.sv
// Reduces DNN score vectors to (class, score), buffers them and tracks end-of-stream.
module dnn_result_sink
   import dnn_result_pkg::*;
#(
   parameter int unsigned BitSize    = PkgBitSize,
   parameter int unsigned NumOut     = PkgNumOut,
   parameter int unsigned Depth      = 4,
   parameter int unsigned CountWidth = 8
) (
   input  logic                              clk,
   input  logic                              res_n,
   input  logic                              in_clear,
   input  logic                              in_valid,
   input  logic [NumOut-1:0][BitSize-1:0]    in_data,
   input  logic                              in_done,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic [$clog2(NumOut)-1:0]         out_class,
   output logic [BitSize-1:0]                out_score,
   output logic                              out_done,
   output logic [CountWidth-1:0]             out_count,
   output logic [CountWidth-1:0]             out_drop
);

   localparam int unsigned ResW = result_width(BitSize, NumOut);

   sink_state_t     state;
   logic            s1_valid;
   result_t         s1_res;
   result_t         head;
   logic [ResW-1:0] fifo_rdata;
   logic            full;
   logic            empty;
   logic            accept;
   logic            pop_req;
   logic            push_ok;

   assign accept  = in_valid && (state != StFinished) && !in_clear;
   assign pop_req = !empty && out_ready;
   assign push_ok = s1_valid && (!full || pop_req);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         s1_valid <= 1'b0;
         s1_res   <= '0;
      end else if (in_clear) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) s1_res <= argmax(in_data);
      end
   end

   result_fifo #(
      .Width (ResW),
      .Depth (Depth)
   ) u_fifo (
      .clk   (clk),
      .res_n (res_n),
      .clear (in_clear),
      .push  (s1_valid),
      .pop   (pop_req),
      .wdata (ResW'(s1_res)),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         out_count <= '0;
         out_drop  <= '0;
      end else if (in_clear) begin
         out_count <= '0;
         out_drop  <= '0;
      end else if (s1_valid) begin
         if (push_ok) begin
            if (out_count != '1) out_count <= out_count + 1'b1;
         end else if (out_drop != '1) begin
            out_drop <= out_drop + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state    <= StCollect;
         out_done <= 1'b0;
      end else if (in_clear) begin
         state    <= StCollect;
         out_done <= 1'b0;
      end else begin
         unique case (state)
            StCollect: if (in_done) state <= StDrain;
            StDrain: begin
               if (!s1_valid && empty) begin
                  state    <= StFinished;
                  out_done <= 1'b1;
               end
            end
            StFinished: out_done <= 1'b1;
            default:    state    <= StCollect;
         endcase
      end
   end

   assign head      = result_t'(fifo_rdata);
   assign out_valid = !empty;
   assign out_class = head.cls;
   assign out_score = head.score;

endmodule

// File: tb/tb_dnn_result_sink.sv
// Directed bench for dnn_result_sink: queue-based reference model plus literal spot checks.
module tb_dnn_result_sink;

   localparam int DEPTH = 4;

   logic            clk;
   logic            res_n;
   logic            in_clear;
   logic            in_valid;
   logic [1:0][3:0] in_data;
   logic            in_done;
   logic            out_ready;
   logic            out_valid;
   logic [0:0]      out_class;
   logic [3:0]      out_score;
   logic            out_done;
   logic [7:0]      out_count;
   logic [7:0]      out_drop;

   int compared   = 0;
   int mismatched = 0;
   bit chk_en     = 0;

   dnn_result_sink #(
      .BitSize    (4),
      .NumOut     (2),
      .Depth      (DEPTH),
      .CountWidth (8)
   ) dut (
      .clk       (clk),
      .res_n     (res_n),
      .in_clear  (in_clear),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_done   (in_done),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_class (out_class),
      .out_score (out_score),
      .out_done  (out_done),
      .out_count (out_count),
      .out_drop  (out_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cls;
      int score;
   } res_t;

   res_t mq[$];
   bit   m_pend  = 0;
   res_t m_pend_r;
   int   m_count = 0;
   int   m_drop  = 0;
   bit   m_drain = 0;
   bit   m_fin   = 0;

   // Largest signed value first, then the first lane holding it.
   function automatic res_t model_argmax(input logic [1:0][3:0] v);
      res_t r;
      int   mx;
      mx = -1000;
      for (int i = 0; i < 2; i++)
         if (int'($signed(v[i])) > mx) mx = int'($signed(v[i]));
      r.cls = -1;
      for (int i = 1; i >= 0; i--)
         if (int'($signed(v[i])) == mx) r.cls = i;
      r.score = mx & 4'hf;
      return r;
   endfunction

   always @(posedge clk or negedge res_n) begin : model
      bit old_pend;
      bit old_empty;
      bit old_fin;
      if (!res_n || in_clear) begin
         mq.delete();
         m_pend  = 0;
         m_count = 0;
         m_drop  = 0;
         m_drain = 0;
         m_fin   = 0;
      end else begin
         old_pend  = m_pend;
         old_empty = (mq.size() == 0);
         old_fin   = m_fin;
         if (mq.size() != 0 && out_ready) void'(mq.pop_front());
         if (old_pend) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(m_pend_r);
               if (m_count < 255) m_count++;
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
         if (m_drain && !old_fin && !old_pend && old_empty) m_fin = 1;
         m_pend = in_valid && !old_fin;
         if (m_pend) m_pend_r = model_argmax(in_data);
         if (in_done && !old_fin) m_drain = 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_valid", int'(out_valid), int'(mq.size() != 0));
         if (mq.size() != 0) begin
            check("model_class", int'(out_class), mq[0].cls);
            check("model_score", int'(out_score), mq[0].score);
         end
         check("model_count", int'(out_count), m_count);
         check("model_drop", int'(out_drop), m_drop);
         check("model_done", int'(out_done), int'(m_fin));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [3:0] l1, input logic [3:0] l0);
      in_valid   = 1'b1;
      in_data[1] = l1;
      in_data[0] = l0;
      tick();
      in_valid   = 1'b0;
   endtask

   task automatic do_clear();
      in_clear = 1'b1;
      tick();
      in_clear = 1'b0;
   endtask

   task automatic first_scenario(input string tag);
      beat(4'b0011, 4'b1110);
      check({tag, "_valid_early"}, int'(out_valid), 0);
      tick();
      check({tag, "_valid"}, int'(out_valid), 1);
      check({tag, "_class"}, int'(out_class), 1);
      check({tag, "_score"}, int'(out_score), 4'b0011);
      check({tag, "_count"}, int'(out_count), 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_popped"}, int'(out_valid), 0);
   endtask

   initial begin
      res_n     = 1'b1;
      in_clear  = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_done   = 1'b0;
      out_ready = 1'b0;
      #2 res_n  = 1'b0;
      chk_en    = 1;
      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_class", int'(out_class), 0);
      check("rst_score", int'(out_score), 0);
      check("rst_done", int'(out_done), 0);
      check("rst_count", int'(out_count), 0);
      check("rst_drop", int'(out_drop), 0);
      repeat (2) @(posedge clk);
      #1 res_n = 1'b1;
      tick();

      first_scenario("s1");

      beat(4'b0010, 4'b0010);
      tick();
      check("tie_class", int'(out_class), 0);
      check("tie_score", int'(out_score), 4'b0010);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      beat(4'b1000, 4'b1111);
      tick();
      check("neg_class", int'(out_class), 0);
      check("neg_score", int'(out_score), 4'b1111);
      check("neg_count", int'(out_count), 3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Overflow: six beats into a four-entry FIFO with no consumer.
      do_clear();
      check("clr_count", int'(out_count), 0);
      for (int i = 0; i < 6; i++) begin
         in_valid   = 1'b1;
         in_data[1] = 4'(i + 1);
         in_data[0] = 4'b0000;
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("ovf_count", int'(out_count), 4);
      check("ovf_drop", int'(out_drop), 2);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("ovf_order", int'(out_score), i + 1);
         tick();
      end
      out_ready = 1'b0;
      check("ovf_empty", int'(out_valid), 0);

      // Fifth push meets a pop on a full FIFO.
      do_clear();
      for (int i = 0; i < 5; i++) begin
         in_valid   = 1'b1;
         in_data[1] = 4'(i + 1);
         in_data[0] = 4'b0000;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("fullpop_drop", int'(out_drop), 0);
      check("fullpop_count", int'(out_count), 5);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("fullpop_order", int'(out_score), i + 2);
         tick();
      end
      out_ready = 1'b0;

      // End of stream.
      do_clear();
      beat(4'b0001, 4'b0101);
      beat(4'b0110, 4'b0010);
      in_done = 1'b1;
      tick();
      in_done = 1'b0;
      repeat (3) tick();
      check("eos_done_held", int'(out_done), 0);
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      check("eos_empty", int'(out_valid), 0);
      check("eos_done_lag", int'(out_done), 0);
      tick();
      check("eos_done", int'(out_done), 1);
      in_done = 1'b1;
      beat(4'b0111, 4'b0000);
      in_done = 1'b0;
      repeat (2) tick();
      check("fin_ignore_valid", int'(out_valid), 0);
      check("fin_ignore_count", int'(out_count), 2);
      do_clear();
      check("fin_clr_done", int'(out_done), 0);
      check("fin_clr_count", int'(out_count), 0);

      // Asynchronous reset with three entries buffered.
      beat(4'b0001, 4'b0000);
      beat(4'b0010, 4'b0000);
      beat(4'b0011, 4'b0000);
      tick();
      check("pre_rst_count", int'(out_count), 3);
      #2 res_n = 1'b0;
      #1;
      check("arst_valid", int'(out_valid), 0);
      check("arst_count", int'(out_count), 0);
      check("arst_drop", int'(out_drop), 0);
      check("arst_done", int'(out_done), 0);
      tick();
      res_n = 1'b1;
      tick();
      first_scenario("post_rst");

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
